// File: rtl/alu_pkg.sv
// Shared definitions for the add/subtract execute stage.
//   alu_op_e : two-bit opcode (ADD, ADDC, SUB, SUBB)
//   DATA_W   : default datapath width
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADDC = 2'b01,
        OP_SUB  = 2'b10,
        OP_SUBB = 2'b11
    } alu_op_e;

    localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/fa_nbit.sv
// n-bit ripple-carry adder.
// Ports:
//   a, b  : WIDTH-bit addends, bit 0 is the MSB
//   cin   : carry into the LSB (bit WIDTH-1)
//   sum   : WIDTH-bit sum, bit 0 is the MSB
//   cout  : carry out of the MSB (bit 0)
module fa_nbit #(
    parameter int unsigned WIDTH = alu_pkg::DATA_W
) (
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             cin,
    output logic [0:WIDTH-1] sum,
    output logic             cout
);

    logic carry;

    // Carry ripples from the LSB (highest index) towards the MSB (index 0).
    // A single running variable keeps the chain free of combinational loops.
    always_comb begin
        sum   = '0;
        carry = cin;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            sum[WIDTH-1-k] = a[WIDTH-1-k] ^ b[WIDTH-1-k] ^ carry;
            carry          = (a[WIDTH-1-k] & b[WIDTH-1-k]) |
                             (carry & (a[WIDTH-1-k] ^ b[WIDTH-1-k]));
        end
        cout = carry;
    end

endmodule

// File: rtl/alu_addsub_stage.sv
// Two-stage registered add/subtract execute stage.
//   S1 latches operand A, conditioned B and conditioned carry-in.
//   S2 latches the ripple-adder sum, raw carry-out, signed overflow and zero.
// Both sides use valid/ready; a transfer happens on an edge with valid && ready.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : upstream handshake
//   in_op             : 00 ADD, 01 ADDC, 10 SUB, 11 SUBB
//   in_a, in_b        : operands, bit 0 is the MSB
//   in_cin            : carry-in (ADDC) or borrow-in (SUBB)
//   out_valid/ready   : downstream handshake
//   out_sum           : result modulo 2^WIDTH, bit 0 is the MSB
//   out_cout          : raw adder carry-out (for SUB, 1 means no borrow)
//   out_ovf           : two's-complement overflow
//   out_zero          : out_sum == 0
module alu_addsub_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [0:WIDTH-1] in_a,
    input  logic [0:WIDTH-1] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    // S1 state
    logic             s1_valid_q, s1_valid_d;
    logic [0:WIDTH-1] a_q, a_d;
    logic [0:WIDTH-1] bm_q, bm_d;
    logic             c_q, c_d;

    // S2 state
    logic             s2_valid_q, s2_valid_d;
    logic [0:WIDTH-1] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Flow control
    logic             s2_free;
    logic             s1_adv;
    logic             s1_load;

    // Operand conditioning and adder results
    logic [0:WIDTH-1] bm_in;
    logic             c_in;
    logic [0:WIDTH-1] add_sum;
    logic             add_cout;

    assign s2_free  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;
    assign s1_adv   = s1_valid_q && s2_free;
    assign s1_load  = in_valid && in_ready;

    // Subtraction is A + ~B + 1; with borrow-in the +1 becomes ~borrow.
    always_comb begin
        bm_in = in_b;
        c_in  = 1'b0;
        unique case (alu_op_e'(in_op))
            OP_ADD: begin
                bm_in = in_b;
                c_in  = 1'b0;
            end
            OP_ADDC: begin
                bm_in = in_b;
                c_in  = in_cin;
            end
            OP_SUB: begin
                bm_in = ~in_b;
                c_in  = 1'b1;
            end
            OP_SUBB: begin
                bm_in = ~in_b;
                c_in  = ~in_cin;
            end
        endcase
    end

    fa_nbit #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a    (a_q),
        .b    (bm_q),
        .cin  (c_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        bm_d       = bm_q;
        c_d        = c_q;
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;

        // A load in the same cycle as an advance refills S1 directly.
        if (s1_load) begin
            s1_valid_d = 1'b1;
            a_d        = in_a;
            bm_d       = bm_in;
            c_d        = c_in;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // S2 drains on out_ready and may refill from S1 in the same edge.
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            sum_d      = add_sum;
            cout_d     = add_cout;
            // Overflow: addends share a sign bit but the sum's sign differs.
            ovf_d      = (a_q[0] == bm_q[0]) && (add_sum[0] != a_q[0]);
            zero_d     = (add_sum == '0);
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            bm_q       <= '0;
            c_q        <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            bm_q       <= bm_d;
            c_q        <= c_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_alu_addsub_stage.sv
module tb_alu_addsub_stage;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [0:W-1] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [0:W-1] in_a;
    logic [0:W-1] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [0:W-1] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int n_out  = 0;
    exp_t sb[$];

    alu_addsub_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        e.zero = z;
        return e;
    endfunction

    // Issue one bundle; expected result is queued on acceptance.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input exp_t e, output int waited);
        logic acc;
        logic accepted;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        waited   = 0;
        accepted = 1'b0;
        while (!accepted && waited < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) accepted = 1'b1;
            else     waited++;
        end
        in_valid = 1'b0;
        if (accepted) begin
            sb.push_back(e);
            n_acc++;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected acceptance");
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_queue_empty", sb.size(), 0);
    endtask

    // Monitor: compares each transferred result with the scoreboard head and
    // checks output stability across stalled cycles.
    logic         prev_stall = 1'b0;
    logic [0:W-1] held_sum;
    logic [2:0]   held_flags;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sum=%h with empty scoreboard expected none", out_sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                n_out++;
                if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf || out_zero !== e.zero) begin
                    errors++;
                    $display("FAIL result%0d: got sum=%h cout=%b ovf=%b zero=%b expected sum=%h cout=%b ovf=%b zero=%b",
                             n_out, out_sum, out_cout, out_ovf, out_zero, e.sum, e.cout, e.ovf, e.zero);
                end
            end
        end
        if (!rst && out_valid && !out_ready) begin
            if (prev_stall) begin
                checks++;
                if (out_sum !== held_sum || {out_cout, out_ovf, out_zero} !== held_flags) begin
                    errors++;
                    $display("FAIL stall_hold: got sum=%h flags=%b expected sum=%h flags=%b",
                             out_sum, {out_cout, out_ovf, out_zero}, held_sum, held_flags);
                end
            end
            prev_stall = 1'b1;
            held_sum   = out_sum;
            held_flags = {out_cout, out_ovf, out_zero};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got simulation still running expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int w;
        int base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_flags", {out_cout, out_ovf, out_zero}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Basic ADD with latency check: out_valid rises two cycles after issue.
        send(OP_ADD, 32'h0000F000, 32'h0000F000, 1'b0, mk(32'h0001E000, 0, 0, 0), w);
        @(negedge clk);
        chk("latency_cycle1_valid", out_valid, 0);
        @(negedge clk);
        chk("latency_cycle2_valid", out_valid, 1);
        @(posedge clk);
        #1;

        send(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 1'b0, mk(32'h00000000, 1, 0, 1), w);
        send(OP_ADDC, 32'hFFFFFFFD, 32'h00000001, 1'b1, mk(32'hFFFFFFFF, 0, 0, 0), w);
        send(OP_SUB,  32'h00000005, 32'h00000007, 1'b0, mk(32'hFFFFFFFE, 0, 0, 0), w);
        send(OP_SUB,  32'h80000000, 32'h00000001, 1'b0, mk(32'h7FFFFFFF, 1, 1, 0), w);
        send(OP_SUBB, 32'h0000000A, 32'h00000003, 1'b1, mk(32'h00000006, 1, 0, 0), w);
        send(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 1'b0, mk(32'h80000000, 0, 1, 0), w);
        drain(20);

        // Backpressure: four ADDs against a stalled output.
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    send(OP_ADD, k, 32'h1, 1'b0, mk(k + 1, 0, 0, 0), w);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_accepted", n_acc - base, 2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(20);

        // Streaming: every bundle accepted without waiting, one result per cycle.
        base = n_out;
        for (int i = 1; i <= 8; i++) begin
            send(OP_ADD, i * 32'h10, i, 1'b0, mk(i * 32'h11, 0, 0, 0), w);
            chk("stream_no_wait", w, 0);
        end
        @(negedge clk);
        chk("stream_valid_tail", out_valid, 1);
        drain(10);
        chk("stream_count", n_out - base, 8);

        // Reset with two bundles in flight: nothing stale may come out.
        out_ready = 1'b0;
        send(OP_ADD, 32'h9, 32'h1, 1'b0, mk(32'hA, 0, 0, 0), w);
        send(OP_ADD, 32'h9, 32'h2, 1'b0, mk(32'hB, 0, 0, 0), w);
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        base = n_out;
        send(OP_ADD, 32'h1, 32'h1, 1'b0, mk(32'h2, 0, 0, 0), w);
        @(negedge clk);
        chk("post_rst_cycle1_valid", out_valid, 0);
        @(negedge clk);
        chk("post_rst_cycle2_valid", out_valid, 1);
        drain(10);
        chk("post_rst_count", n_out - base, 1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
